// File: rtl/net_sample_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : net_sample_bridge
//  Purpose  : Audio-rate side of the network handshake. Issues one forward-
//             pass request per frame (toggle), captures the packed 4-channel
//             result on the synchronised done toggle, drives slew-limited,
//             jack-muted outputs and counts late/abandoned requests.
//  Revision : 1.0  initial release
// ============================================================================
module net_sample_bridge #(
    parameter int             W        = 16,
    parameter int             BUDGET   = 1,
    parameter int             TIMEOUT  = 4,
    parameter logic [W-1:0]   MAX_STEP = 16'h0400,
    parameter int             CNT_W    = 16
) (
    input  logic             sample_clk,
    input  logic             rst,
    input  logic             net_done_toggle,
    input  logic [4*W-1:0]   net_out,
    input  logic [7:0]       jack,
    output logic             req_toggle,
    output logic [W-1:0]     sample_out0,
    output logic [W-1:0]     sample_out1,
    output logic [W-1:0]     sample_out2,
    output logic [W-1:0]     sample_out3,
    output logic             stale,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int              c_wait_w = $clog2(TIMEOUT + 1);
    localparam logic signed [W:0] c_step  = {1'b0, MAX_STEP};
    localparam logic signed [W:0] c_nstep = -c_step;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic                w_done_pulse;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_next;
    logic [W-1:0]        r_target [4];
    logic [W-1:0]        r_out    [4];
    logic                w_unused_jack;

    assign w_done_pulse  = r_s2 ^ r_s3;
    assign w_wait_next   = r_wait_cnt + 1'b1;
    assign w_unused_jack = ^jack[7:4];

    // Move one step of at most MAX_STEP from cur toward tgt; the difference
    // is taken one bit wider so the comparison never wraps.
    function automatic logic [W-1:0] f_slew(input logic [W-1:0] cur,
                                            input logic [W-1:0] tgt);
        logic signed [W:0] d;
        d = $signed({tgt[W-1], tgt}) - $signed({cur[W-1], cur});
        if (d > c_step)
            f_slew = cur + MAX_STEP;
        else if (d < c_nstep)
            f_slew = cur - MAX_STEP;
        else
            f_slew = tgt;
    endfunction

    // Three-flop synchroniser for the network-domain done toggle.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= net_done_toggle;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Request/response sequencer: capture on done, otherwise age the
    // outstanding request, flag it stale, and reissue it on timeout.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            req_toggle    <= 1'b0;
            r_wait_cnt    <= '0;
            stale         <= 1'b0;
            frame_count   <= '0;
            timeout_count <= '0;
            for (int i = 0; i < 4; i++) r_target[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    req_toggle <= ~req_toggle;
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done_pulse) begin
                        // A done on the timeout tick is a normal completion.
                        for (int i = 0; i < 4; i++)
                            r_target[i] <= net_out[(3-i)*W +: W];
                        if (frame_count != '1)
                            frame_count <= frame_count + 1'b1;
                        req_toggle <= ~req_toggle;
                        r_wait_cnt <= '0;
                        stale      <= 1'b0;
                    end else if (w_wait_next == c_wait_w'(TIMEOUT)) begin
                        if (timeout_count != '1)
                            timeout_count <= timeout_count + 1'b1;
                        req_toggle <= ~req_toggle;
                        r_wait_cnt <= '0;
                        stale      <= 1'b0;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                        if (w_wait_next > c_wait_w'(BUDGET))
                            stale <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output stage: mute on unplugged jack, else slew toward the (pre-capture)
    // target; muting keeps the target so the ramp restarts from zero.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_out[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!jack[i])
                    r_out[i] <= '0;
                else if (MAX_STEP == '0)
                    r_out[i] <= r_target[i];
                else
                    r_out[i] <= f_slew(r_out[i], r_target[i]);
            end
        end
    end

    assign sample_out0 = r_out[0];
    assign sample_out1 = r_out[1];
    assign sample_out2 = r_out[2];
    assign sample_out3 = r_out[3];

endmodule
`default_nettype wire

// File: tb/tb_net_sample_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_net_sample_bridge
//  Purpose  : Scoreboard bench for net_sample_bridge with a randomised network
//             responder and a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_net_sample_bridge;

    localparam int W       = 16;
    localparam int BUDGET  = 1;
    localparam int TIMEOUT = 4;
    localparam int STEP    = 'h0400;
    localparam int CNT_MAX = 65535;

    logic        sample_clk = 1'b0;
    logic        rst        = 1'b1;
    logic        net_done_toggle = 1'b0;
    logic [63:0] net_out    = '0;
    logic [7:0]  jack       = 8'h0F;

    logic        req_toggle, stale;
    logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic [15:0] frame_count, timeout_count;

    logic        ns_req, ns_stale;
    logic [15:0] ns_out0, ns_out1, ns_out2, ns_out3;
    logic [15:0] ns_fc, ns_tc;

    int total = 0;
    int bad   = 0;

    always #5 sample_clk = ~sample_clk;

    net_sample_bridge #(.W(W), .BUDGET(BUDGET), .TIMEOUT(TIMEOUT),
                        .MAX_STEP(16'h0400), .CNT_W(16)) dut (
        .sample_clk(sample_clk), .rst(rst), .net_done_toggle(net_done_toggle),
        .net_out(net_out), .jack(jack), .req_toggle(req_toggle),
        .sample_out0(sample_out0), .sample_out1(sample_out1),
        .sample_out2(sample_out2), .sample_out3(sample_out3),
        .stale(stale), .frame_count(frame_count), .timeout_count(timeout_count));

    // Same inputs, no slew limiting: outputs must jump straight to target.
    net_sample_bridge #(.W(W), .BUDGET(BUDGET), .TIMEOUT(TIMEOUT),
                        .MAX_STEP(16'h0000), .CNT_W(16)) dut_ns (
        .sample_clk(sample_clk), .rst(rst), .net_done_toggle(net_done_toggle),
        .net_out(net_out), .jack(jack), .req_toggle(ns_req),
        .sample_out0(ns_out0), .sample_out1(ns_out1),
        .sample_out2(ns_out2), .sample_out3(ns_out3),
        .stale(ns_stale), .frame_count(ns_fc), .timeout_count(ns_tc));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- network responder ----------------
    bit          resp_en    = 0;
    int          delay_mode = -1;    // >=0 fixed delay, -1 random
    bit          fixed_en   = 0;
    logic [63:0] fixed_data = '0;
    int          pending    = -1;
    logic        last_req   = 1'b0;

    function automatic logic [15:0] rand_ch();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'($urandom_range(0, 'h600));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic int pick_delay();
        int r;
        if (delay_mode >= 0) return delay_mode;
        r = int'($urandom_range(0, 9));
        if (r == 9) return -1;          // request never answered
        return r % 6;
    endfunction

    always @(negedge sample_clk) begin
        if (rst) begin
            pending  = -1;
            last_req = 1'b0;
        end else begin
            if (req_toggle !== last_req) begin
                last_req = req_toggle;
                if (pending < 0 && resp_en) pending = pick_delay();
            end
            if (pending == 0) begin
                net_out = fixed_en ? fixed_data : {rand_ch(), rand_ch(), rand_ch(), rand_ch()};
                net_done_toggle = ~net_done_toggle;
                pending = -1;
            end else if (pending > 0) begin
                pending--;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic        req;
        logic [63:0] o;
        logic [63:0] z;
        logic        stale;
        logic [15:0] fc;
        logic [15:0] tc;
    } exp_t;

    exp_t sb_q[$];

    bit m_hist[3];
    bit m_run, m_req, m_stale;
    int m_age, m_fc, m_tc;
    int m_tgt[4], m_o[4], m_z[4];

    function automatic int slew(input int cur, input int tgt, input bit en, input int step);
        int d;
        if (!en) return 0;
        if (step == 0) return tgt;
        d = tgt - cur;
        if (d > step) d = step;
        if (d < -step) d = -step;
        return cur + d;
    endfunction

    always @(posedge sample_clk) begin
        exp_t e;
        bit   seen;
        if (rst) begin
            m_hist = '{0, 0, 0};
            m_run = 0; m_req = 0; m_stale = 0; m_age = 0; m_fc = 0; m_tc = 0;
            for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_o[i] = 0; m_z[i] = 0; end
        end else begin
            // a done flip becomes visible once it has passed two sync stages
            seen = m_hist[1] ^ m_hist[2];
            for (int i = 0; i < 4; i++) begin
                m_o[i] = slew(m_o[i], m_tgt[i], jack[i], STEP);
                m_z[i] = slew(m_z[i], m_tgt[i], jack[i], 0);
            end
            if (!m_run) begin
                m_run = 1; m_req = ~m_req; m_age = 0;
            end else if (seen) begin
                for (int i = 0; i < 4; i++)
                    m_tgt[i] = int'($signed(net_out[(3-i)*16 +: 16]));
                if (m_fc < CNT_MAX) m_fc++;
                m_req = ~m_req; m_age = 0; m_stale = 0;
            end else begin
                m_age++;
                if (m_age == TIMEOUT) begin
                    if (m_tc < CNT_MAX) m_tc++;
                    m_req = ~m_req; m_age = 0; m_stale = 0;
                end else if (m_age > BUDGET) begin
                    m_stale = 1;
                end
            end
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = net_done_toggle;
        end
        e.req   = m_req;
        e.o     = {16'(m_o[0]), 16'(m_o[1]), 16'(m_o[2]), 16'(m_o[3])};
        e.z     = {16'(m_z[0]), 16'(m_z[1]), 16'(m_z[2]), 16'(m_z[3])};
        e.stale = m_stale;
        e.fc    = 16'(m_fc);
        e.tc    = 16'(m_tc);
        sb_q.push_back(e);
    end

    // Monitor: outputs are presented every tick; compare shortly after the edge.
    always @(posedge sample_clk) begin
        exp_t e;
        #2;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty got=0 exp=1 t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            chk("req_toggle", 64'(req_toggle), 64'(e.req));
            chk("sample_out", {sample_out0, sample_out1, sample_out2, sample_out3}, e.o);
            chk("sample_out_noslew", {ns_out0, ns_out1, ns_out2, ns_out3}, e.z);
            chk("stale", 64'(stale), 64'(e.stale));
            chk("frame_count", 64'(frame_count), 64'(e.fc));
            chk("timeout_count", 64'(timeout_count), 64'(e.tc));
            chk("noslew_req", 64'(ns_req), 64'(e.req));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1'b1;
        repeat (3) @(negedge sample_clk);
        rst = 1'b0;

        // no network answer: IDLE tick, first request, stale, timeout reissue
        repeat (12) @(negedge sample_clk);

        // answer one tick after each request edge (done lands on timeout tick);
        // ch1 ramps to -4096, ch2 muted while its target is 0x2000
        fixed_data = {16'h1000, 16'hF000, 16'h2000, 16'h0000};
        fixed_en   = 1;
        delay_mode = 1;
        jack       = 8'h0B;
        resp_en    = 1;
        repeat (25) @(negedge sample_clk);

        // plug ch2: ramp 0400, 0800 ... 2000
        jack = 8'h0F;
        repeat (15) @(negedge sample_clk);

        // randomised responses, data and jack pattern
        fixed_en   = 0;
        delay_mode = -1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int b = 0; b < 4; b++) jack[b] = ($urandom_range(0, 4) != 0);
                jack[7:4] = 4'($urandom);
            end
            @(negedge sample_clk);
        end

        // asynchronous reset in the middle of a stale request
        guard = 0;
        while (stale !== 1'b1 && guard < 40) begin
            @(negedge sample_clk);
            guard++;
        end
        chk("stale_seen_before_reset", 64'(guard < 40), 64'(1));
        #3 rst = 1'b1;
        #1;
        chk("async_rst_req", 64'(req_toggle), 64'(0));
        chk("async_rst_out", {sample_out0, sample_out1, sample_out2, sample_out3}, 64'(0));
        chk("async_rst_out_noslew", {ns_out0, ns_out1, ns_out2, ns_out3}, 64'(0));
        chk("async_rst_stale", 64'(stale), 64'(0));
        chk("async_rst_fc", 64'(frame_count), 64'(0));
        chk("async_rst_tc", 64'(timeout_count), 64'(0));
        repeat (2) @(negedge sample_clk);
        rst = 1'b0;
        repeat (60) @(negedge sample_clk);

        repeat (2) @(negedge sample_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
